// File: rtl/rbs_serial_sub_45bit.sv
// rtl/rbs_serial_sub_45bit.sv - multi-cycle ripple-borrow subtractor, CHUNK bits per clock, valid/ready wrapped
module rbs_serial_sub_45bit #(
    parameter int WIDTH = 45,
    parameter int CHUNK = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);

    localparam int NCHUNK = (CHUNK < 1) ? 1 : (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
        $error("rbs_serial_sub_45bit: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             ready_q;
    logic [PW-1:0]    a_q, b_q;
    logic [WIDTH-1:0] diff_q, diff_next;
    logic             borrow_q, chunk_bout;
    logic [KW-1:0]    k;
    logic [WIDTH:0]   result_q;
    logic             last_chunk;

    assign last_chunk = (int'(k) == NCHUNK - 1);
    assign o_ready    = ready_q;
    assign o_valid    = (state == DONE);
    assign o_result   = result_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid && ready_q) state_next = RUN;
            RUN:     if (last_chunk)         state_next = DONE;
            DONE:    if (i_ready)            state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ready is registered so it stays low for the whole reset and the release edge
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == IDLE);
        end
    end

    // Operands are zero-padded to PW bits, so padding bits just pass the borrow through
    always_comb begin : chunk_calc
        int            base;
        logic          b;
        logic [CHUNK-1:0] ca, cb, cd;
        logic [PW-1:0] mask, val;
        base = int'(k) * CHUNK;
        ca   = CHUNK'(a_q >> base);
        cb   = CHUNK'(b_q >> base);
        b    = borrow_q;
        cd   = '0;
        for (int j = 0; j < CHUNK; j++) begin
            cd[j] = ca[j] ^ cb[j] ^ b;
            b     = (~ca[j] & cb[j]) | (~(ca[j] ^ cb[j]) & b);
        end
        chunk_bout = b;
        mask       = PW'({CHUNK{1'b1}}) << base;
        val        = PW'(cd) << base;
        diff_next  = WIDTH'((PW'(diff_q) & ~mask) | (val & mask));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            k        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && ready_q) begin
                        a_q      <= PW'(i_minuend);
                        b_q      <= PW'(i_subtrahend);
                        borrow_q <= 1'b0;
                        k        <= '0;
                    end
                end
                RUN: begin
                    diff_q   <= diff_next;
                    borrow_q <= chunk_bout;
                    k        <= k + 1'b1;
                    if (last_chunk) result_q <= {chunk_bout, diff_next};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rbs_serial_sub_45bit.sv
// tb/tb_rbs_serial_sub_45bit.sv - directed and random checks for CHUNK=9, 45 and 7 instances
module tb_rbs_serial_sub_45bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        rdy_in;
    logic [44:0] mina, subb;
    logic [2:0]  ready, ov;
    logic [45:0] res [3];

    int n_tests = 0;
    int n_fail  = 0;
    int nch [3] = '{5, 1, 7};

    always #5 clk = ~clk;

    rbs_serial_sub_45bit #(.WIDTH(45), .CHUNK(9)) u_d9 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready[0]),
        .i_minuend(mina), .i_subtrahend(subb), .o_valid(ov[0]), .i_ready(rdy_in),
        .o_result(res[0]));
    rbs_serial_sub_45bit #(.WIDTH(45), .CHUNK(45)) u_d45 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready[1]),
        .i_minuend(mina), .i_subtrahend(subb), .o_valid(ov[1]), .i_ready(rdy_in),
        .o_result(res[1]));
    rbs_serial_sub_45bit #(.WIDTH(45), .CHUNK(7)) u_d7 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready[2]),
        .i_minuend(mina), .i_subtrahend(subb), .o_valid(ov[2]), .i_ready(rdy_in),
        .o_result(res[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (ready !== 3'b111 && guard < 30) begin
            step();
            guard++;
        end
        check({tag, "_rdy"}, 64'(ready), 64'h7);
    endtask

    task automatic run_op(input logic [44:0] a, input logic [44:0] b,
                          input logic [45:0] exp, input string tag);
        int          lat [3];
        logic [45:0] got [3];
        bit          seen [3];
        wait_ready(tag);
        mina  = a;
        subb  = b;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            seen[d] = 1'b0;
            lat[d]  = 0;
            got[d]  = '0;
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = c;
                    got[d]  = res[d];
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_lat%0d", tag, d), 64'(lat[d]), 64'(nch[d]));
            check($sformatf("%s_res%0d", tag, d), 64'(got[d]), 64'(exp));
        end
    endtask

    initial begin
        logic [44:0] ra, rb;
        logic [45:0] gold;
        bit          any_v;

        rst_n  = 1'b0;
        valid  = 1'b0;
        rdy_in = 1'b1;
        mina   = '0;
        subb   = '0;
        step();
        step();
        check("rst_valid", 64'(ov[0]), 64'h0);
        check("rst_result", 64'(res[0]), 64'h0);
        check("rst_ready", 64'(ready[0]), 64'h0);
        rst_n = 1'b1;
        step();
        check("rel_ready", 64'(ready[0]), 64'h1);

        run_op(45'd10, 45'd3, 46'h7, "t1");
        run_op(45'd0, 45'd1, 46'h3FFF_FFFF_FFFF, "t2");
        run_op(45'h200, 45'd1, 46'h1FF, "t3");
        run_op(45'h1234, 45'h1234, 46'h0, "eq");
        run_op(45'h1FFF_FFFF_FFFF, 45'd0, 46'h1FFF_FFFF_FFFF, "max0");
        run_op(45'd0, 45'h1FFF_FFFF_FFFF, 46'h2000_0000_0001, "0max");
        run_op(45'h100_0000_0000, 45'h1, 46'h0FF_FFFF_FFFF, "tail");

        // result held while downstream stalls; new operands must be ignored
        wait_ready("hold");
        rdy_in = 1'b0;
        mina   = 45'd5;
        subb   = 45'd2;
        valid  = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 0; c < 12 && !ov[0]; c++) step();
        check("hold_v_rise", 64'(ov[0]), 64'h1);
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            mina  = 45'(100 + i);
            subb  = 45'd1;
            step();
            check($sformatf("hold_v%0d", i), 64'(ov[0]), 64'h1);
            check($sformatf("hold_res%0d", i), 64'(res[0]), 64'h3);
            check($sformatf("hold_rdy%0d", i), 64'(ready[0]), 64'h0);
        end
        valid  = 1'b0;
        rdy_in = 1'b1;
        step();
        check("rel_v", 64'(ov[0]), 64'h0);
        check("rel_rdy", 64'(ready[0]), 64'h1);
        check("rel_hold_res", 64'(res[0]), 64'h3);

        // reset on the second RUN cycle aborts the operation
        wait_ready("abort");
        mina  = 45'd7;
        subb  = 45'd1;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("abort_v", 64'(ov[0]), 64'h0);
        check("abort_res", 64'(res[0]), 64'h0);
        check("abort_rdy", 64'(ready[0]), 64'h0);
        rst_n = 1'b1;
        step();
        check("abort_rel_rdy", 64'(ready[0]), 64'h1);
        any_v = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (ov[0]) any_v = 1'b1;
            step();
        end
        check("abort_no_v", 64'(any_v), 64'h0);

        for (int n = 0; n < 2000; n++) begin
            ra   = 45'({$urandom, $urandom});
            rb   = (n % 16 == 0) ? ra : 45'({$urandom, $urandom});
            gold = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, gold, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
